// File: rtl/fetch_prefetch_buffer.sv
// fetch_prefetch_buffer: FETCH-stage prefetcher. Issues word requests on the
// instruction bus, keeps responses in a DEPTH-entry FIFO, and presents one
// aligned instruction per cycle to DECODE over a valid/ready handshake.
// Build option FETCH_RVC_EN: when defined, RV32C 16-bit instructions are aligned
// out of the word stream; when undefined every instruction is a 32-bit word and a
// halfword-aligned redirect produces one error instruction followed by a stall.
module fetch_prefetch_buffer #(
  parameter int          DEPTH           = 3,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        is_compressed_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i
);

  localparam int          CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C  = DEPTH[CW:0];
  localparam logic [CW:0] MAXOUT_C = MAX_OUTSTANDING[CW:0];

  // Zero-extend a single event bit to counter width.
  function automatic logic [CW-1:0] bit2cnt(input logic b);
    return {{(CW-1){1'b0}}, b};
  endfunction

  // FIFO storage: entry 0 is always the oldest word.
  logic [31:0]      data_r [DEPTH];
  logic [31:0]      data_s [DEPTH];
  logic [DEPTH-1:0] err_r;
  logic [DEPTH-1:0] err_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_s;
  logic [CW-1:0]    base_s;

  // Bus bookkeeping.
  logic [CW-1:0]    outstanding_r;
  logic [CW-1:0]    outstanding_s;
  logic [CW-1:0]    discard_r;
  logic [CW-1:0]    discard_s;
  logic [31:0]      fetch_addr_r;
  logic [31:0]      hold_addr_r;
  logic             hold_r;
  logic             stale_r;
  logic [31:0]      pc_r;
  logic [31:0]      pc_s;

  logic             credit_ok_s;
  logic             req_s;
  logic             gnt_fire_s;
  logic             gnt_stale_s;
  logic             gnt_live_s;
  logic             rv_live_s;
  logic             rv_disc_s;
  logic             pop_eff_s;

  // Aligner results.
  logic             out_valid_s;
  logic [31:0]      out_rdata_s;
  logic             out_comp_s;
  logic             out_err_s;
  logic             pop_s;
  logic [31:0]      pc_step_s;
  logic             accept_s;

  // A request already on the bus is held until granted; otherwise it needs
  // FIFO room for every in-flight word plus a free transaction credit.
  assign credit_ok_s = (({1'b0, count_r} + {1'b0, outstanding_r}) < DEPTH_C) &&
                       (({1'b0, outstanding_r} + {1'b0, discard_r}) < MAXOUT_C);
  assign req_s        = ~rst & (hold_r | (req_i & credit_ok_s));
  assign instr_req_o  = req_s;
  assign instr_addr_o = hold_r ? hold_addr_r : fetch_addr_r;
  assign busy_o       = (outstanding_r != {CW{1'b0}}) | (discard_r != {CW{1'b0}}) | req_s;

  // A grant is stale if its request predates a redirect (or coincides with one).
  assign gnt_fire_s  = req_s & instr_gnt_i;
  assign gnt_stale_s = gnt_fire_s & ((hold_r & stale_r) | branch_i);
  assign gnt_live_s  = gnt_fire_s & ~gnt_stale_s;
  // Responses return in order, so discarded ones always come first.
  assign rv_disc_s   = instr_rvalid_i & (discard_r != {CW{1'b0}});
  assign rv_live_s   = instr_rvalid_i & (discard_r == {CW{1'b0}});

  assign accept_s  = out_valid_s & ready_i;
  assign pop_eff_s = accept_s & pop_s & ~branch_i;

  // Outstanding/discard accounting; a redirect turns everything in flight into discards.
  always_comb begin
    outstanding_s = outstanding_r;
    discard_s     = discard_r;
    if (branch_i) begin
      outstanding_s = {CW{1'b0}};
      discard_s     = discard_r + outstanding_r + bit2cnt(gnt_fire_s)
                      - bit2cnt(rv_live_s) - bit2cnt(rv_disc_s);
    end else begin
      outstanding_s = outstanding_r + bit2cnt(gnt_live_s) - bit2cnt(rv_live_s);
      discard_s     = discard_r + bit2cnt(gnt_stale_s) - bit2cnt(rv_disc_s);
    end
  end

  // FIFO next state: shift down on pop, then write at the new lowest free slot.
  always_comb begin
    data_s  = data_r;
    err_s   = err_r;
    base_s  = count_r - bit2cnt(pop_eff_s);
    count_s = count_r;
    if (branch_i) begin
      count_s = {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_s[i] = (pop_eff_s && (i < DEPTH - 1)) ? data_r[(i < DEPTH - 1) ? i + 1 : i] : data_r[i];
        err_s[i]  = (pop_eff_s && (i < DEPTH - 1)) ? err_r[(i < DEPTH - 1) ? i + 1 : i] : err_r[i];
        data_s[i] = (rv_live_s && (base_s == i[CW-1:0])) ? instr_rdata_i : data_s[i];
        err_s[i]  = (rv_live_s && (base_s == i[CW-1:0])) ? instr_err_i : err_s[i];
      end
      count_s = base_s + bit2cnt(rv_live_s);
    end
  end

`ifdef FETCH_RVC_EN
  // RV32C aligner: pick a 16-bit or 32-bit instruction starting at pc.
  always_comb begin
    out_valid_s = 1'b0;
    out_rdata_s = 32'h0;
    out_comp_s  = 1'b0;
    out_err_s   = 1'b0;
    pop_s       = 1'b0;
    pc_step_s   = 32'd4;
    if (!pc_r[1]) begin
      out_valid_s = (count_r != {CW{1'b0}});
      out_err_s   = err_r[0];
      out_comp_s  = ~err_r[0] & (data_r[0][1:0] != 2'b11);
      out_rdata_s = out_comp_s ? {16'h0, data_r[0][15:0]} : data_r[0];
      pop_s       = ~out_comp_s;
      pc_step_s   = out_comp_s ? 32'd2 : 32'd4;
    end else if (err_r[0]) begin
      out_valid_s = (count_r != {CW{1'b0}});
      out_err_s   = 1'b1;
      pop_s       = 1'b1;
    end else if (data_r[0][17:16] != 2'b11) begin
      out_valid_s = (count_r != {CW{1'b0}});
      out_comp_s  = 1'b1;
      out_rdata_s = {16'h0, data_r[0][31:16]};
      pop_s       = 1'b1;
      pc_step_s   = 32'd2;
    end else begin
      out_valid_s = (count_r > bit2cnt(1'b1));
      out_err_s   = err_r[1];
      out_rdata_s = {data_r[1][15:0], data_r[0][31:16]};
      pop_s       = 1'b1;
      pc_step_s   = 32'd4;
    end
  end
`else
  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MISALIGN = 2'b01,
    ST_STALL    = 2'b10
  } mis_state_e;

  mis_state_e state_r;
  mis_state_e state_s;

  // Misaligned-target state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Halfword targets report one error then stall until the next redirect.
  always_comb begin
    state_s = state_r;
    if (branch_i) begin
      state_s = branch_addr_i[1] ? ST_MISALIGN : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:      state_s = ST_RUN;
        ST_MISALIGN: state_s = ready_i ? ST_STALL : ST_MISALIGN;
        ST_STALL:    state_s = ST_STALL;
        default:     state_s = ST_RUN;
      endcase
    end
  end

  // Word-only aligner: every instruction is entry 0.
  always_comb begin
    out_valid_s = 1'b0;
    out_rdata_s = 32'h0;
    out_comp_s  = 1'b0;
    out_err_s   = 1'b0;
    pop_s       = 1'b0;
    pc_step_s   = 32'd4;
    case (state_r)
      ST_RUN: begin
        out_valid_s = (count_r != {CW{1'b0}});
        out_err_s   = err_r[0];
        out_rdata_s = data_r[0];
        pop_s       = 1'b1;
      end
      ST_MISALIGN: begin
        out_valid_s = 1'b1;
        out_err_s   = 1'b1;
      end
      ST_STALL: begin
        out_valid_s = 1'b0;
      end
      default: begin
        out_valid_s = 1'b0;
      end
    endcase
  end
`endif

  // Program counter: redirect beats accept; an error jumps to the next word.
  always_comb begin
    pc_s = pc_r;
    if (branch_i) begin
      pc_s = {branch_addr_i[31:1], 1'b0};
    end else if (accept_s) begin
      pc_s = out_err_s ? {pc_r[31:2] + 30'd1, 2'b00} : pc_r + pc_step_s;
    end else begin
      pc_s = pc_r;
    end
  end

  assign valid_o         = out_valid_s;
  assign rdata_o         = out_valid_s ? out_rdata_s : 32'h0;
  assign is_compressed_o = out_valid_s & out_comp_s;
  assign err_o           = out_valid_s & out_err_s;
  assign addr_o          = pc_r;

  // State registers for FIFO, counters, request hold and fetch/pc addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= 32'h0;
      end
      err_r         <= {DEPTH{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
      fetch_addr_r  <= BOOT_ADDR;
      hold_addr_r   <= 32'h0;
      hold_r        <= 1'b0;
      stale_r       <= 1'b0;
      pc_r          <= BOOT_ADDR;
    end else begin
      data_r        <= data_s;
      err_r         <= err_s;
      count_r       <= count_s;
      outstanding_r <= outstanding_s;
      discard_r     <= discard_s;
      pc_r          <= pc_s;
      if (branch_i) begin
        fetch_addr_r <= {branch_addr_i[31:2], 2'b00};
      end else if (gnt_live_s) begin
        fetch_addr_r <= fetch_addr_r + 32'd4;
      end else begin
        fetch_addr_r <= fetch_addr_r;
      end
      if (gnt_fire_s) begin
        hold_r  <= 1'b0;
        stale_r <= 1'b0;
      end else if (req_s) begin
        hold_r      <= 1'b1;
        hold_addr_r <= instr_addr_o;
        stale_r     <= (hold_r & stale_r) | branch_i;
      end else begin
        hold_r  <= 1'b0;
        stale_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb_fetch_prefetch_buffer: directed bench with a bus responder, a grant-address
// scoreboard and an instruction scoreboard checked by a separate monitor.
module tb_fetch_prefetch_buffer;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        is_compressed_o;
  logic        err_o;
  logic        busy_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  fetch_prefetch_buffer #(
    .DEPTH(3), .MAX_OUTSTANDING(2), .BOOT_ADDR(32'h100)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .valid_o(valid_o), .ready_i(ready_i),
    .rdata_o(rdata_o), .addr_o(addr_o), .is_compressed_o(is_compressed_o),
    .err_o(err_o), .busy_o(busy_o), .instr_req_o(instr_req_o),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        comp;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    int          due;
  } rsp_t;

  exp_t        exp_q[$];
  logic [31:0] gnt_q[$];
  rsp_t        rsp_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rsp_lat = 1;
  logic        ready_en = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h000: return 32'h00010001;
      32'h004: return 32'h00130013;
      32'h010: return 32'h00930001;
      32'h014: return 32'h00000010;
      32'h204: return 32'h00050013;
      default: return {a[15:0], 16'h0013};
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic e);
    exp_t x;
    x.addr = a; x.rdata = d; x.comp = c; x.err = e;
    return x;
  endfunction

  // Bus responder: grants one cycle after a request is seen, answers rsp_lat cycles later.
  initial begin
    logic gnt_prev;
    logic req_prev;
    rsp_t r;
    gnt_prev = 1'b0; req_prev = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; instr_err_i = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rsp_q.delete();
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; instr_err_i = 1'b0;
        gnt_prev = 1'b0; req_prev = 1'b0;
      end else begin
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          r = rsp_q.pop_front();
          instr_rvalid_i = 1'b1; instr_rdata_i = r.data; instr_err_i = r.err;
        end else begin
          instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; instr_err_i = 1'b0;
        end
        if (instr_req_o && req_prev && !gnt_prev) begin
          instr_gnt_i = 1'b1;
          if (gnt_q.size() > 0) chk("grant_addr", instr_addr_o, gnt_q.pop_front());
          r.data = mem_word(instr_addr_o);
          r.err  = (instr_addr_o == err_addr);
          r.due  = cyc + rsp_lat;
          rsp_q.push_back(r);
        end else begin
          instr_gnt_i = 1'b0;
        end
        gnt_prev = instr_gnt_i;
        req_prev = instr_req_o;
      end
    end
  end

  // Monitor: accepts only while an expectation is pending and checks every accepted instruction.
  initial begin
    exp_t e;
    ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ready_i = 1'b0;
      end else begin
        ready_i = ready_en && (exp_q.size() > 0);
        if (valid_o && ready_i) begin
          e = exp_q.pop_front();
          chk("out_addr", addr_o, e.addr);
          chk("out_err", {31'h0, err_o}, {31'h0, e.err});
          chk("out_comp", {31'h0, is_compressed_o}, {31'h0, e.comp});
          if (!e.err) chk("out_rdata", rdata_o, e.rdata);
        end
      end
    end
  end

  task automatic redirect(input logic [31:0] a);
    @(posedge clk); #1;
    branch_i = 1'b1; branch_addr_i = a;
    @(posedge clk); #1;
    branch_i = 1'b0;
  endtask

  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 req_i = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_req", {31'h0, instr_req_o}, 32'h0);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_comp", {31'h0, is_compressed_o}, 32'h0);

    // Boot fetch from 0x100.
    gnt_q.push_back(32'h100); gnt_q.push_back(32'h104); gnt_q.push_back(32'h108);
    exp_q.push_back(mk(32'h100, 32'h01000013, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h104, 32'h01040013, 1'b0, 1'b0));
    @(posedge clk); #1 rst = 1'b0; ready_en = 1'b1;
    drain("boot_drain", 200);
    repeat (6) @(posedge clk);
    chk("boot_grants_left", gnt_q.size(), 32'd0);
    gnt_q.delete();

    // Compressed pair then a 32-bit word.
    redirect(32'h0);
`ifdef FETCH_RVC_EN
    exp_q.push_back(mk(32'h0, 32'h00000001, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h2, 32'h00000001, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h4, 32'h00130013, 1'b0, 1'b0));
`else
    exp_q.push_back(mk(32'h0, 32'h00010001, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h4, 32'h00130013, 1'b0, 1'b0));
`endif
    drain("rvc_drain", 200);

    // Instruction straddling a word boundary.
    redirect(32'h10);
`ifdef FETCH_RVC_EN
    exp_q.push_back(mk(32'h10, 32'h00000001, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h12, 32'h00100093, 1'b0, 1'b0));
`else
    exp_q.push_back(mk(32'h10, 32'h00930001, 1'b0, 1'b0));
    exp_q.push_back(mk(32'h14, 32'h00000010, 1'b0, 1'b0));
`endif
    drain("straddle_drain", 200);
    repeat (10) @(posedge clk);

    // Redirect to 0x206 with two transactions in flight.
    rsp_lat = 6;
    redirect(32'h300);
    n = 0;
    while (rsp_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("two_outstanding", rsp_q.size(), 32'd2);
    redirect(32'h206);
    gnt_q.push_back(32'h204);
    rsp_lat = 1;
`ifdef FETCH_RVC_EN
    exp_q.push_back(mk(32'h206, 32'h00000005, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h208, 32'h02080013, 1'b0, 1'b0));
    drain("stale_drain", 200);
`else
    exp_q.push_back(mk(32'h206, 32'h0, 1'b0, 1'b1));
    drain("stale_drain", 200);
    repeat (8) begin
      @(negedge clk);
      chk("misalign_stall_valid", {31'h0, valid_o}, 32'h0);
    end
`endif
    repeat (20) @(posedge clk);
    chk("redirect_grant_left", gnt_q.size(), 32'd0);
    gnt_q.delete();

    // Back-pressure: FIFO fills, requests stop, nothing is lost.
    redirect(32'h400);
    ready_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(32'h400 + 32'd4 * i, {16'h0400 + 16'd4 * i[15:0], 16'h0013}, 1'b0, 1'b0));
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_req", {31'h0, instr_req_o}, 32'h0);
    chk("full_busy", {31'h0, busy_o}, 32'h0);
    chk("full_valid", {31'h0, valid_o}, 32'h1);
    ready_en = 1'b1;
    drain("full_drain", 200);

    // Bus error on the word at 0x8.
    err_addr = 32'h8;
    redirect(32'h8);
    exp_q.push_back(mk(32'h8, 32'h0, 1'b0, 1'b1));
    exp_q.push_back(mk(32'hC, 32'h000C0013, 1'b0, 1'b0));
    drain("err_drain", 200);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
